// File: rtl/inst_fifo.sv
// Instruction fetch-to-decode queue: dual-push, dual-issue circular buffer.
// Optional same-cycle bypass of pushed entries when INST_FIFO_BYPASS_EN is defined.
module inst_fifo #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [1:0]              push_en,
  input  logic [1:0][ENTRY_W-1:0] push_entry,
  output logic                    push_ready,
  input  logic [1:0]              issue_en,
  output logic [1:0][ENTRY_W-1:0] id_pipe,
  output logic [1:0]              out_valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      head_q, tail_q, head_p1, tail_p1;
  logic [CW-1:0]      count_q;
  logic               push_acc0, push_acc1;
  logic               pop0, pop1;
  logic               wr0, wr1;
  logic [1:0]         push_num, pop_num;

  assign count   = count_q;
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Ready looks only at the registered count, so a full queue never accepts
  // a push on the strength of a pop happening in the same cycle.
  assign push_ready = (count_q <= CW'(DEPTH - 2));
  assign push_acc0  = push_ready & push_en[0];
  assign push_acc1  = push_acc0 & push_en[1];
  assign push_num   = {1'b0, push_acc0} + {1'b0, push_acc1};

  always_comb begin
    id_pipe[0] = mem[head_q];
    id_pipe[1] = mem[head_p1];
    out_valid  = {count_q >= CW'(2), count_q != '0};
`ifdef INST_FIFO_BYPASS_EN
    // Incoming entries queue up logically behind the stored ones.
    if (!flush) begin
      if (count_q == '0) begin
        id_pipe   = push_entry;
        out_valid = {push_acc1, push_acc0};
      end else if (count_q == CW'(1)) begin
        id_pipe[1]   = push_entry[0];
        out_valid[1] = push_acc0;
      end
    end
`endif
  end

  assign pop0    = issue_en[0] & out_valid[0];
  assign pop1    = pop0 & issue_en[1] & out_valid[1];
  assign pop_num = {1'b0, pop0} + {1'b0, pop1};

  always_comb begin
    wr0 = push_acc0;
    wr1 = push_acc1;
`ifdef INST_FIFO_BYPASS_EN
    // Entries consumed straight off the bypass never land in storage.
    if (((count_q == '0) && pop0) || ((count_q == CW'(1)) && pop1))
      wr0 = 1'b0;
    if ((count_q == '0) && pop1)
      wr1 = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(pop_num);
      tail_q  <= tail_q + AW'(push_num);
      count_q <= count_q + CW'(push_num) - CW'(pop_num);
    end
  end

  // Storage has no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr0) mem[tail_q]  <= push_entry[0];
      if (wr1) mem[tail_p1] <= push_entry[1];
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed vector table, corner sequences
// and a randomized run against a queue-based model.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [1:0]       push_en, issue_en;
  logic [1:0][31:0] push_entry;
  logic             push_ready;
  logic [1:0][31:0] id_pipe;
  logic [1:0]       out_valid;
  logic [4:0]       count;

  int tests_run = 0;
  int tests_failed = 0;

  inst_fifo #(.DEPTH(DEPTH), .ENTRY_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en(push_en), .push_entry(push_entry), .push_ready(push_ready),
    .issue_en(issue_en), .id_pipe(id_pipe), .out_valid(out_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [1:0]  push_en;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  issue_en;
    logic [4:0]  exp_count;
    logic [1:0]  exp_valid;
    logic        exp_ready;
    logic [31:0] exp_id0;
    logic [31:0] exp_id1;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    rst = 1'b0; flush = 1'b0; push_en = 2'b00; issue_en = 2'b00;
    push_entry[0] = '0; push_entry[1] = '0;
  endtask

  // One clock with the given inputs; returns #1 after the edge with inputs idle.
  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] pe,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] ie);
    @(negedge clk);
    rst = r; flush = f; push_en = pe; issue_en = ie;
    push_entry[0] = e0; push_entry[1] = e1;
    @(posedge clk);
    #1;
    setIdle();
    #1;
  endtask

  task automatic checkState(input string tag, input logic [4:0] c, input logic [1:0] v,
                            input logic r);
    checkOutput({tag, ".count"}, 32'(count), 32'(c));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    checkOutput({tag, ".push_ready"}, 32'(push_ready), 32'(r));
  endtask

  // Reference model: a plain queue of live entries, oldest first.
  logic [31:0] q[$];
  logic [31:0] vq[$];
  int unsigned next_tag;
  bit          bypass_build;

  initial begin
`ifdef INST_FIFO_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
    setIdle();

    vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 2'b00, 1'b1, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 2'b11, 32'hA, 32'hB, 2'b00, 5'd2, 2'b11, 1'b1, 32'hA, 32'hB};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'hC, 32'h0, 2'b00, 5'd3, 2'b11, 1'b1, 32'hA, 32'hB};
    vecs[3]  = '{1'b0, 1'b0, 2'b11, 32'hD, 32'hE, 2'b01, 5'd4, 2'b11, 1'b1, 32'hB, 32'hC};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b10, 5'd4, 2'b11, 1'b1, 32'hB, 32'hC};
    vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'hF, 32'h0, 2'b11, 5'd3, 2'b11, 1'b1, 32'hD, 32'hE};
    vecs[6]  = '{1'b0, 1'b0, 2'b11, 32'h10, 32'h11, 2'b00, 5'd5, 2'b11, 1'b1, 32'hD, 32'hE};
    vecs[7]  = '{1'b0, 1'b1, 2'b11, 32'h12, 32'h13, 2'b11, 5'd0, 2'b00, 1'b1, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 32'h20, 32'h0, 2'b00, 5'd1, 2'b01, 1'b1, 32'h20, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 32'h21, 32'h22, 2'b01, 5'd0, 2'b00, 1'b1, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 32'h30, 32'h31, 2'b00, 5'd2, 2'b11, 1'b1, 32'h30, 32'h31};

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].push_en, vecs[i].e0, vecs[i].e1,
                    vecs[i].issue_en);
      checkState(tag, vecs[i].exp_count, vecs[i].exp_valid, vecs[i].exp_ready);
      if (vecs[i].exp_valid[0]) checkOutput({tag, ".id0"}, id_pipe[0], vecs[i].exp_id0);
      if (vecs[i].exp_valid[1]) checkOutput({tag, ".id1"}, id_pipe[1], vecs[i].exp_id1);
    end

    // Fill to the top: ready drops at 15 and 16, extra pushes are dropped.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 2'b00);
    checkState("fill14", 5'd14, 2'b11, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h10E, 32'h10F, 2'b00);
    checkState("fill16", 5'd16, 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b11, 32'hBAD0, 32'hBAD1, 2'b00);
    checkState("full_drop", 5'd16, 2'b11, 1'b0);
    checkOutput("full_drop.id0", id_pipe[0], 32'h100);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    checkState("fill15", 5'd15, 2'b11, 1'b0);
    checkOutput("fill15.id0", id_pipe[0], 32'h101);
    applyStimulus(1'b0, 1'b0, 2'b01, 32'hBAD2, 32'h0, 2'b00);
    checkState("fill15_drop", 5'd15, 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    checkState("fill13", 5'd13, 2'b11, 1'b1);
    checkOutput("fill13.id1", id_pipe[1], 32'h104);

    // Empty queue, push and issue two in the same cycle.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    push_en = 2'b11; push_entry[0] = 32'hC; push_entry[1] = 32'hD; issue_en = 2'b11;
    #1;
    if (bypass_build) begin
      checkOutput("byp.out_valid", 32'(out_valid), 32'h3);
      checkOutput("byp.id0", id_pipe[0], 32'hC);
      checkOutput("byp.id1", id_pipe[1], 32'hD);
    end else begin
      checkOutput("nobyp.out_valid", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    setIdle();
    #1;
    checkOutput("byp.count", 32'(count), bypass_build ? 32'd0 : 32'd2);

    // Randomized run against the queue model.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    q.delete();
    next_tag = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int          r;
      logic        exp_ready, acc0, acc1, v0, v1;
      int          pops;
      @(negedge clk);
      r = int'($urandom_range(0, 3));
      push_en  = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      issue_en = 2'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 99) < 1);
      push_entry[0] = 32'(next_tag);
      push_entry[1] = 32'(next_tag + 1);
      #1;
      exp_ready = (DEPTH - q.size()) >= 2;
      acc0 = exp_ready && push_en[0];
      acc1 = acc0 && push_en[1];
      vq = q;
      if (bypass_build && !flush) begin
        if (acc0) vq.push_back(push_entry[0]);
        if (acc1) vq.push_back(push_entry[1]);
      end
      v0 = vq.size() >= 1;
      v1 = vq.size() >= 2;
      checkOutput($sformatf("rnd%0d.count", cyc), 32'(count), 32'(q.size()));
      checkOutput($sformatf("rnd%0d.ready", cyc), 32'(push_ready), 32'(exp_ready));
      checkOutput($sformatf("rnd%0d.valid", cyc), 32'(out_valid), 32'({v1, v0}));
      if (v0) checkOutput($sformatf("rnd%0d.id0", cyc), id_pipe[0], vq[0]);
      if (v1) checkOutput($sformatf("rnd%0d.id1", cyc), id_pipe[1], vq[1]);
      pops = (issue_en[0] && v0) ? ((issue_en[1] && v1) ? 2 : 1) : 0;
      @(posedge clk);
      if (rst || flush) begin
        q.delete();
      end else begin
        if (acc0) q.push_back(push_entry[0]);
        if (acc1) q.push_back(push_entry[1]);
        for (int k = 0; k < pops; k++) void'(q.pop_front());
      end
      if (acc0) next_tag = next_tag + (acc1 ? 2 : 1);
    end
    #1;
    setIdle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the entry count (power of two, >=4).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port flush  input  1  discard all entries (branch mispredict or exception redirect).
REQ-005 The block SHALL have port push_en  input  2  fetch write strobes; push_en[1] is legal only with push_en[0].
REQ-006 The block SHALL have port push_entry  input  pipe_entry_t[1:0]  fetched entries; slot 0 is older.
REQ-007 The block SHALL have port push_ready  output  1  high when at least 2 slots are free.
REQ-008 The block SHALL have port issue_en  input  2  ID-stage consume strobes; issue_en[1] is legal only with issue_en[0].
REQ-009 The block SHALL have port id_pipe  output  pipe_entry_t[1:0]  the oldest two entries; slot 0 is oldest.
REQ-010 The block SHALL have port out_valid  output  2  validity of id_pipe slots.
REQ-011 The block SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-012 Storage SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-013 id_pipe[0] SHALL be mem[head] and id_pipe[1] SHALL be mem[head+1 mod DEPTH]; both SHALL be combinational reads.
REQ-014 out_valid[0] SHALL equal (count>=1), and out_valid[1] SHALL equal (count>=2).
REQ-015 push_ready SHALL equal (DEPTH-count>=2), computed from registered count only, with no pop credit.
REQ-016 When push_ready is high, push_en[0] SHALL write mem[tail], and push_en[1] SHALL also write mem[tail+1].
REQ-017 Pushes SHALL be accepted only when push_ready is high; pushes while it is low SHALL be dropped, and fetch SHALL hold them.
REQ-018 Pops SHALL be pop0=issue_en[0]&out_valid[0] and pop1=pop0&issue_en[1]&out_valid[1]; strobes without valid SHALL be ignored.
REQ-019 On each edge: head SHALL advance by pop0+pop1, tail SHALL advance by the accepted push count, and count SHALL change by pushes minus pops.
REQ-020 Simultaneous push and pop SHALL both take effect in the same cycle.
REQ-021 Count SHALL never exceed DEPTH or drop below 0.
REQ-022 flush SHALL set head=tail=count=0 on the next edge, overriding any push and pop in that cycle.
REQ-023 Entry contents SHALL NOT be cleared by flush or reset; only the pointers are reset.
REQ-024 Out-of-order pops (issue_en=2'b10) SHALL be treated as no pop.

Reset
REQ-025 While rst is high at a clock edge, the block SHALL set head=0, tail=0 and count=0.
REQ-026 After reset, outputs SHALL be out_valid=2'b00, push_ready=1 and count=0; id_pipe contents are don't-care while invalid.
REQ-027 Reset SHALL take priority over flush, push and pop.
REQ-028 Reset asserted mid-stream SHALL discard all entries with no partial pop.

Configuration
REQ-029 With INST_FIFO_BYPASS_EN defined and count==0, push_entry SHALL drive id_pipe and out_valid=push_en in the same cycle.
REQ-030 With INST_FIFO_BYPASS_EN defined, bypassed entries popped that cycle SHALL NOT be written, and unpopped ones SHALL be stored at head.
REQ-031 With INST_FIFO_BYPASS_EN defined, count==1 with one push SHALL present mem[head] in slot 0 and push_entry[0] in slot 1.
REQ-032 Without INST_FIFO_BYPASS_EN, pushed entries SHALL become visible on id_pipe one cycle after the push edge.
REQ-033 flush SHALL suppress the bypass path in the same cycle in both builds.

Verification
REQ-034 Reset, then push A,B in cycle 0 with issue_en=00 -> cycle 1 shows out_valid=11, id_pipe={B,A}, count=2.
REQ-035 Fill 16 entries without popping -> push_ready=0 at count 15 and 16; a further push is dropped and count stays 16.
REQ-036 Count=3, issue_en=01 with a push of 2 in the same cycle -> count=4 next cycle and head advances by 1.
REQ-037 Run 40 entries through with random issue_en while pointers wrap -> output order equals push order with no loss or duplication.
REQ-038 Count=5, then flush together with push_en=11 and issue_en=11 -> next cycle count=0, out_valid=00, push_ready=1.
REQ-039 With bypass built, empty FIFO, push C,D and issue_en=11 -> C,D consumed in the same cycle and count stays 0; without bypass, out_valid=00 that cycle.
